// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sweep sequencer.
//
// Contents:
//   sweep_state_t  - FSM encoding for counter_sweep_ctrl
//   MODE_UP/DOWN   - encoding of the counter's mode input
//   timer_width()  - width of the pause down-counter for a given pause length
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_UP      = 3'd2,
        S_PAUSE_U = 3'd3,
        S_DOWN    = 3'd4,
        S_PAUSE_D = 3'd5,
        S_DONE    = 3'd6
    } sweep_state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // A pause of one cycle loads 0, which still needs a 1-bit register.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter that times the idle gap between sweep directions.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset (value clears to 0)
//   load     - load PAUSE_CYCLES-1
//   dec      - decrement by one (saturates at 0)
//   expired  - value is 0
module pause_timer
    import counter_ctrl_pkg::*;
#(
    parameter int PAUSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int            W          = timer_width(PAUSE_CYCLES);
    localparam logic [W-1:0]  LOAD_VALUE = W'(PAUSE_CYCLES - 1);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= LOAD_VALUE;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that runs a requested number of full up/down sweeps (0 -> max -> 0)
// on an external enable/mode counter, pausing between direction changes.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   start       - one-cycle run request, sampled only in IDLE
//   num_sweeps  - number of sweeps, captured with an accepted start
//   abort       - stop the current run and return to IDLE (no done)
//   count_in    - counter value
//   tc_in       - counter terminal count (combinational in the counter)
//   cnt_enable  - counter enable
//   cnt_mode    - counter direction, 0 = up, 1 = down
//   cnt_clear   - one-cycle active-high counter clear
//   busy        - run in progress (any state but IDLE)
//   done        - one-cycle pulse on normal completion
//   sweeps_done - completed up+down sweeps in the current/last run
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; counter parked, mode up
// CLEAR     | one-cycle counter clear, progress reset
// UP        | counting up until the top end, holding one cycle there
// PAUSE_U   | enable low, mode already down, pause timer running
// DOWN      | counting down until zero, then sweep counted
// PAUSE_D   | enable low, mode already up, pause timer running
// DONE      | one-cycle completion pulse
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int PAUSE_CYCLES = 2,   // must be at least 1
    parameter int SWEEPS_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SWEEPS_W-1:0] num_sweeps,
    input  logic                abort,
    input  logic [CNT_W-1:0]    count_in,
    input  logic                tc_in,
    output logic                cnt_enable,
    output logic                cnt_mode,
    output logic                cnt_clear,
    output logic                busy,
    output logic                done,
    output logic [SWEEPS_W-1:0] sweeps_done
);

    sweep_state_t        state;
    sweep_state_t        state_nxt;
    logic [SWEEPS_W-1:0] target;
    logic [SWEEPS_W-1:0] sweeps_inc;
    logic                zero_done;
    logic                timer_load;
    logic                timer_dec;
    logic                timer_expired;
    logic                sweep_step;
    logic                at_max;
    logic                at_zero;
    logic                run_accept;
    logic                zero_accept;
    logic                abort_hit;

    // End detection accepts either the counter's flag or the count itself.
    // Under the counter contract they agree; using both keeps the turnaround
    // on time even if a counter variant registers its terminal count.
    assign at_max  = tc_in || (count_in == {CNT_W{1'b1}});
    assign at_zero = tc_in || (count_in == '0);

    assign sweeps_inc  = sweeps_done + SWEEPS_W'(1);
    assign run_accept  = (state == S_IDLE) && start && (num_sweeps != '0);
    assign zero_accept = (state == S_IDLE) && start && (num_sweeps == '0);
    assign abort_hit   = abort && (state != S_IDLE);

    pause_timer #(
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) u_pause_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-sweep request never leaves IDLE; zero_done supplies its done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target      <= '0;
            sweeps_done <= '0;
            zero_done   <= 1'b0;
        end else begin
            zero_done <= zero_accept;
            if (run_accept) begin
                target <= num_sweeps;
            end
            if (zero_accept || ((state == S_CLEAR) && !abort)) begin
                sweeps_done <= '0;
            end else if (sweep_step) begin
                sweeps_done <= sweeps_inc;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_enable = 1'b0;
        cnt_mode   = MODE_UP;
        cnt_clear  = 1'b0;
        busy       = (state != S_IDLE);
        done       = zero_done;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        sweep_step = 1'b0;

        case (state)
            S_IDLE: begin
                if (run_accept) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clear = 1'b1;
                state_nxt = S_UP;
            end
            S_UP: begin
                cnt_mode   = MODE_UP;
                cnt_enable = !at_max;
                if (at_max) begin
                    timer_load = 1'b1;
                    state_nxt  = S_PAUSE_U;
                end
            end
            S_PAUSE_U: begin
                // Mode flips here so the counter's terminal count drops
                // before DOWN starts.
                cnt_mode  = MODE_DOWN;
                timer_dec = 1'b1;
                if (timer_expired) begin
                    state_nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                cnt_mode   = MODE_DOWN;
                cnt_enable = !at_zero;
                if (at_zero) begin
                    sweep_step = 1'b1;
                    if (sweeps_inc == target) begin
                        state_nxt = S_DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_nxt  = S_PAUSE_D;
                    end
                end
            end
            S_PAUSE_D: begin
                cnt_mode  = MODE_UP;
                timer_dec = 1'b1;
                if (timer_expired) begin
                    state_nxt = S_UP;
                end
            end
            S_DONE: begin
                cnt_mode  = MODE_DOWN;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE in the same cycle.
        if (abort_hit) begin
            state_nxt  = S_IDLE;
            cnt_enable = 1'b0;
            timer_load = 1'b0;
            sweep_step = 1'b0;
            if (state == S_DONE) begin
                done = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;

    localparam int CNT_W        = 4;
    localparam int PAUSE_CYCLES = 2;
    localparam int SWEEPS_W     = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [SWEEPS_W-1:0] num_sweeps = '0;
    logic                abort = 1'b0;
    logic [CNT_W-1:0]    cnt = 4'd5;
    logic                tc;
    logic                stuck = 1'b0;
    logic                cnt_enable;
    logic                cnt_mode;
    logic                cnt_clear;
    logic                busy;
    logic                done;
    logic [SWEEPS_W-1:0] sweeps_done;

    counter_sweep_ctrl #(
        .CNT_W        (CNT_W),
        .PAUSE_CYCLES (PAUSE_CYCLES),
        .SWEEPS_W     (SWEEPS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_sweeps  (num_sweeps),
        .abort       (abort),
        .count_in    (cnt),
        .tc_in       (tc),
        .cnt_enable  (cnt_enable),
        .cnt_mode    (cnt_mode),
        .cnt_clear   (cnt_clear),
        .busy        (busy),
        .done        (done),
        .sweeps_done (sweeps_done)
    );

    always #5 clk = ~clk;

    // Behavioural counter_4bit_ext; 'stuck' pins it at max.
    assign tc = cnt_mode ? (cnt == 4'd0) : (cnt == 4'd15);
    always @(posedge clk) begin
        if (stuck)           cnt <= 4'd15;
        else if (cnt_clear)  cnt <= 4'd0;
        else if (cnt_enable) cnt <= cnt_mode ? cnt - 4'd1 : cnt + 4'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int e0 = 0;

    typedef struct {
        int sweeps;
        int lat;
    } exp_t;
    exp_t done_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the scoreboard queue.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", int'(prev_done), 0);
            check("done_expected", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                exp_t e;
                e = done_q.pop_front();
                check("done_sweeps", int'(sweeps_done), e.sweeps);
                check("done_latency", cyc - e0, e.lat);
            end
        end
        prev_done = done;
    end

    // Leaves the bench at the negedge after the start edge (offset 0).
    task automatic run_start(input int n, input bit push, input int exp_sw, input int lat);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        num_sweeps = SWEEPS_W'(n);
        e0         = cyc + 1;
        if (push) begin
            e.sweeps = exp_sw;
            e.lat    = lat;
            done_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && !done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check(name, ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, int'(cnt_enable), 0);
        check({tag, "_mode"},   int'(cnt_mode), 0);
        check({tag, "_clear"},  int'(cnt_clear), 0);
        check({tag, "_busy"},   int'(busy), 0);
        check({tag, "_done"},   int'(done), 0);
        check({tag, "_sweeps"}, int'(sweeps_done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        // Reset values
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single sweep with cycle-exact shape
        run_start(1, 1'b1, 1, 35);
        for (int k = 0; k <= 36; k++) begin
            case (k)
                0: begin
                    check("s1_clear_k0", int'(cnt_clear), 1);
                    check("s1_busy_k0", int'(busy), 1);
                end
                1: begin
                    check("s1_clear_k1", int'(cnt_clear), 0);
                    check("s1_count_k1", int'(cnt), 0);
                    check("s1_enable_k1", int'(cnt_enable), 1);
                end
                16: begin
                    check("s1_count_top", int'(cnt), 15);
                    check("s1_enable_hold", int'(cnt_enable), 0);
                    check("s1_mode_up", int'(cnt_mode), 0);
                end
                17: begin
                    check("s1_pause_mode", int'(cnt_mode), 1);
                    check("s1_pause_enable", int'(cnt_enable), 0);
                    check("s1_pause_count", int'(cnt), 15);
                end
                18: check("s1_pause2_enable", int'(cnt_enable), 0);
                19: begin
                    check("s1_down_enable", int'(cnt_enable), 1);
                    check("s1_down_count", int'(cnt), 15);
                end
                35: begin
                    check("s1_end_sweeps", int'(sweeps_done), 1);
                    check("s1_end_count", int'(cnt), 0);
                    check("s1_end_busy", int'(busy), 1);
                end
                36: begin
                    check("s1_idle_busy", int'(busy), 0);
                    check("s1_idle_mode", int'(cnt_mode), 0);
                end
                default: ;
            endcase
            @(negedge clk);
        end

        // Three sweeps
        run_start(3, 1'b1, 3, 107);
        for (int k = 0; k <= 108; k++) begin
            case (k)
                35:  check("s3_sweeps_1", int'(sweeps_done), 1);
                36: begin
                    check("s3_pause_d_mode", int'(cnt_mode), 0);
                    check("s3_pause_d_enable", int'(cnt_enable), 0);
                end
                52:  check("s3_second_top", int'(cnt), 15);
                53:  check("s3_second_pause_mode", int'(cnt_mode), 1);
                71:  check("s3_sweeps_2", int'(sweeps_done), 2);
                107: check("s3_sweeps_3", int'(sweeps_done), 3);
                108: check("s3_idle_busy", int'(busy), 0);
                default: ;
            endcase
            @(negedge clk);
        end

        // Abort during the second DOWN at count 9
        run_start(3, 1'b0, 0, 0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy && sweeps_done == 4'd1 && cnt_mode && cnt == 4'd9) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reach_count9", found, 1);
        abort = 1'b1;
        #1;
        check("abort_enable_comb", int'(cnt_enable), 0);
        check("abort_busy_same", int'(busy), 1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_next", int'(busy), 0);
        check("abort_count_hold", int'(cnt), 9);
        check("abort_sweeps", int'(sweeps_done), 1);
        repeat (40) @(negedge clk);
        check("abort_count_still", int'(cnt), 9);

        // Zero-sweep request
        run_start(0, 1'b1, 0, 0);
        check("zero_no_clear", int'(cnt_clear), 0);
        check("zero_not_busy", int'(busy), 0);
        check("zero_enable", int'(cnt_enable), 0);
        check("zero_sweeps", int'(sweeps_done), 0);
        @(negedge clk);
        check("zero_done_gone", int'(done), 0);
        check("zero_enable2", int'(cnt_enable), 0);

        // Second start while busy is ignored
        run_start(2, 1'b1, 2, 71);
        repeat (10) @(negedge clk);
        start      = 1'b1;
        num_sweeps = 4'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart_idle_timeout", 200);
        check("restart_sweeps", int'(sweeps_done), 2);

        // Stuck counter at max on entry to UP
        @(negedge clk);
        stuck = 1'b1;
        run_start(1, 1'b1, 1, 20);
        @(negedge clk);
        check("stuck_up_enable", int'(cnt_enable), 0);
        check("stuck_up_mode", int'(cnt_mode), 0);
        check("stuck_up_busy", int'(busy), 1);
        stuck = 1'b0;
        @(negedge clk);
        check("stuck_pause_mode", int'(cnt_mode), 1);
        check("stuck_pause_count", int'(cnt), 15);
        wait_idle("stuck_idle_timeout", 100);

        // Asynchronous reset mid-UP (second sweep, count 7)
        run_start(2, 1'b0, 0, 0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy && sweeps_done == 4'd1 && !cnt_mode && cnt == 4'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_count7", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_enable", int'(cnt_enable), 0);
        check("post_rst_count", int'(cnt), 7);

        check("scoreboard_empty", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Upstream sequencer for counter_4bit_ext.
- Drives the counter's enable, mode and reset to run a programmable number of full up/down sweeps (0→max→0).
- Watches the counter's count and terminal_count to turn around at each end, with a fixed pause between directions.
- Gives test/system logic a start/done handshake in place of hand-timed enable/mode toggling.

Parameters:
- CNT_W, 4, width of the counter being driven.
- PAUSE_CYCLES, 2, idle cycles (enable low) between direction changes; legal range ≥1.
- SWEEPS_W, 4, width of the sweep-count request and progress outputs.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- num_sweeps  input  SWEEPS_W  sweep count; captured on the accepted start.
- abort  input  1  terminate the current run; returns to IDLE.
- count_in  input  CNT_W  counter value, from counter.count.
- tc_in  input  1  counter terminal_count.
- cnt_enable  output  1  to counter.enable.
- cnt_mode  output  1  to counter.mode; 0 = up, 1 = down.
- cnt_clear  output  1  to counter.rst; active-high, one cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at normal completion.
- sweeps_done  output  SWEEPS_W  number of completed up+down sweeps.

Behaviour:
- Counter contract:
  - tc_in is combinational.
  - tc_in is high when count_in is all-ones with mode=0, or when count_in is 0 with mode=1.
  - The counter updates on the clk edge when enable is high.
- Reset (rst low, async):
  - state=IDLE.
  - cnt_enable=0, cnt_mode=0, cnt_clear=0, busy=0, done=0, sweeps_done=0.
  - Pause timer=0.
- States: IDLE, CLEAR, UP, PAUSE_U, DOWN, PAUSE_D, DONE.
- IDLE:
  - start with num_sweeps≠0 → CLEAR; num_sweeps is latched into the target register.
  - start with num_sweeps=0 → stay IDLE; done pulses the next cycle; sweeps_done=0.
- CLEAR:
  - cnt_clear=1 for exactly one cycle; sweeps_done←0.
  - → UP.
- UP:
  - cnt_mode=0.
  - cnt_enable = !tc_in (Mealy), so the counter holds at max and never wraps.
  - tc_in high → PAUSE_U; the pause timer loads PAUSE_CYCLES−1.
- PAUSE_U:
  - cnt_enable=0, cnt_mode=1. Mode flips on entry, so tc_in falls.
  - Timer decrements each cycle; at 0 → DOWN.
- DOWN:
  - cnt_mode=1, cnt_enable = !tc_in.
  - tc_in high → sweeps_done+1.
  - If the new value equals the target → DONE; else → PAUSE_D with the timer loaded.
- PAUSE_D:
  - cnt_enable=0, cnt_mode=0.
  - Timer at 0 → UP.
- DONE:
  - done=1 for one cycle, busy=1, cnt_enable=0.
  - → IDLE. cnt_mode returns to 0 in IDLE.
- abort:
  - Highest priority in every non-IDLE state.
  - cnt_enable forced 0 combinationally in the same cycle.
  - Next state IDLE; no done pulse; sweeps_done holds its value.
  - Ignored in IDLE.
- start while busy: ignored; num_sweeps is not re-sampled.
- Per-sweep latency with CNT_W=4:
  - 2^CNT_W cycles in UP, PAUSE_CYCLES in PAUSE_U, 2^CNT_W cycles in DOWN.
  - Each UP/DOWN count includes the one hold cycle at the end value.
- sweeps_done never wraps: the run terminates when it reaches the target, and the target is at most 2^SWEEPS_W−1.
- tc_in high on entry to UP (counter not cleared, stuck at max): leave UP after one cycle with no increment. This is legal; no error flag.

Decomposition:
- Package counter_ctrl_pkg:
  - sweep_state_t enum for the seven states.
  - MODE_UP=1'b0, MODE_DOWN=1'b1 constants.
- Sub-module pause_timer:
  - Loadable down-counter of width $clog2(PAUSE_CYCLES).
  - Inputs load, dec; output expired = (value==0).
- The top level holds the FSM, the target register and the sweeps_done register.

Test Plan:
- Reset → rst low mid-UP with count=7 → all outputs 0 asynchronously; after release, state IDLE and no counter activity.
- Single sweep (CNT_W=4, PAUSE_CYCLES=2, num_sweeps=1), start sampled at edge 0:
  - cnt_clear high in cycle 1.
  - count 0→15 and held one cycle, with cnt_enable low while count=15.
  - 2 pause cycles, then count 15→0.
  - done high for exactly one cycle starting at edge 35; sweeps_done=1; busy low at edge 36.
- num_sweeps=3 → count shows three 0→15→0 triangles; sweeps_done steps 1, 2, 3; a single done pulse after the third.
- abort during the second DOWN at count=9:
  - cnt_enable low the same cycle; count holds 9; IDLE next cycle.
  - No done pulse; sweeps_done=1.
- start with num_sweeps=0 → no cnt_clear, cnt_enable stays 0, done pulses one cycle later. A second start pulse while busy on a normal run is ignored: total sweeps equal the first request.
- Stuck counter: hold count_in=15 and tc_in=1 in UP → UP lasts one cycle with cnt_enable=0, then PAUSE_U proceeds normally.
